// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: mem_op codes, FSM states and
// small op-decode helpers.
package mem_pkg;

  localparam logic [2:0] MEM_OP_B  = 3'd0;
  localparam logic [2:0] MEM_OP_H  = 3'd1;
  localparam logic [2:0] MEM_OP_W  = 3'd2;
  localparam logic [2:0] MEM_OP_BU = 3'd4;
  localparam logic [2:0] MEM_OP_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  // Unlisted codes decode as word so a corrupt op can never narrow an access.
  function automatic mem_size_t op_size(input logic [2:0] op);
    case (op)
      MEM_OP_B, MEM_OP_BU: return SZ_B;
      MEM_OP_H, MEM_OP_HU: return SZ_H;
      default:             return SZ_W;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == MEM_OP_B) || (op == MEM_OP_H);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data-memory accesses: store replication and strobes,
// load extraction with sign/zero extension, and alignment checking.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];
  assign sext     = op_signed(op);

  always_comb begin
    misaligned = 1'b0;
    wdata      = store_data;
    wstrb      = 4'hF;
    load_data  = rdata;
    case (op_size(op))
      SZ_B: begin
        wdata     = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << offset;
        load_data = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        misaligned = offset[0];
        wdata      = {2{store_data[15:0]}};
        wstrb      = 4'b0011 << offset;
        load_data  = {{16{sext & half_sel[15]}}, half_sel};
      end
      default: begin
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: one req/ack bus transaction per load/store,
// result presented to the MEM->WB register with stall_out holding upstream stages.
//
// state | meaning
// IDLE  | no access in flight; non-memory entries pass straight through
// WAIT  | dmem_req held, waiting for dmem_ack or the ack timeout
// RESP  | one-cycle result presentation, MEM->WB captures here
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic [31:0] mem_data_out,
  output logic        valid_out,
  output logic        stall_out,
  output logic        misalign_fault,
  output logic        bus_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  mem_state_t       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [2:0]       op_q;
  logic [1:0]       off_q;

  logic        mem_acc;
  logic        acc_store;
  logic [2:0]  op_sel;
  logic [1:0]  off_sel;
  logic        misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_load;

  assign mem_acc   = valid_in & (is_load | is_store);
  // Load+store together is illegal; it is resolved as a load.
  assign acc_store = is_store & ~is_load;

  // Lane logic sees the live op in IDLE and the latched op once the access is in flight.
  assign op_sel  = (state == ST_IDLE) ? mem_op : op_q;
  assign off_sel = (state == ST_IDLE) ? addr_in[1:0] : off_q;

  mem_lane_align u_lane_align (
    .op         (op_sel),
    .offset     (off_sel),
    .store_data (store_data_in),
    .rdata      (dmem_rdata),
    .misaligned (misaligned),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (lane_load)
  );

  always_comb begin
    valid_out = 1'b0;
    stall_out = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          valid_out = valid_in & ~mem_acc;
          stall_out = mem_acc;
        end
        ST_WAIT: stall_out = 1'b1;
        ST_RESP: valid_out = 1'b1;
        default: begin
          valid_out = 1'b0;
          stall_out = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= '0;
      mem_data_out   <= '0;
      misalign_fault <= 1'b0;
      bus_error      <= 1'b0;
      tmo_cnt        <= '0;
      op_q           <= '0;
      off_q          <= '0;
    end else begin
      misalign_fault <= 1'b0;
      bus_error      <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_data_out <= '0;
          if (mem_acc) begin
            op_q  <= mem_op;
            off_q <= addr_in[1:0];
            if (misaligned) begin
              misalign_fault <= 1'b1;
              state          <= ST_RESP;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= acc_store;
              dmem_addr  <= {addr_in[31:2], 2'b00};
              dmem_wdata <= acc_store ? lane_wdata : 32'h0;
              dmem_wstrb <= acc_store ? lane_wstrb : 4'h0;
              // Down-counter: terminal count at zero marks the last WAIT cycle.
              tmo_cnt    <= CNT_W'(TIMEOUT_CYCLES - 1);
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            mem_data_out <= dmem_we ? 32'h0 : lane_load;
            state        <= ST_RESP;
          end else if (tmo_cnt == '0) begin
            dmem_req     <= 1'b0;
            bus_error    <= 1'b1;
            mem_data_out <= '0;
            state        <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          mem_data_out <= '0;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit: expected responses are queued at
// stimulus time and popped whenever valid_out is presented.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        is_load;
  logic        is_store;
  logic [2:0]  mem_op;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [31:0] mem_data_out;
  logic        valid_out;
  logic        stall_out;
  logic        misalign_fault;
  logic        bus_error;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   checks   = 0;
  int   failures = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .is_load        (is_load),
    .is_store       (is_store),
    .mem_op         (mem_op),
    .addr_in        (addr_in),
    .store_data_in  (store_data_in),
    .mem_data_out   (mem_data_out),
    .valid_out      (valid_out),
    .stall_out      (stall_out),
    .misalign_fault (misalign_fault),
    .bus_error      (bus_error),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every presented result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && valid_out === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected_valid observed=valid_out_high expected=no_result_pending");
      end
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        check32("sb_mem_data", mem_data_out, sb_e.data);
        check32("sb_misalign", {31'b0, misalign_fault}, {31'b0, sb_e.mis});
        check32("sb_bus_error", {31'b0, bus_error}, {31'b0, sb_e.berr});
      end
    end
  end

  task automatic run(input string name, input logic ld, input logic st, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] sdata, input int ack_at,
                     input logic [31:0] rdata, input logic [31:0] exp_data, input logic exp_mis,
                     input logic exp_berr, input logic [31:0] exp_addr, input logic exp_we,
                     input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                     input int exp_stall, input int exp_req);
    int   stall_n = 0;
    int   req_n   = 0;
    int   mis_n   = 0;
    int   berr_n  = 0;
    int   cyc     = 0;
    bit   got     = 1'b0;
    exp_t e;
    e.data = exp_data;
    e.mis  = exp_mis;
    e.berr = exp_berr;
    exp_q.push_back(e);
    valid_in      = 1'b1;
    is_load       = ld;
    is_store      = st;
    mem_op        = op;
    addr_in       = addr;
    store_data_in = sdata;
    while (cyc < 40 && !got) begin
      dmem_ack   = (ack_at != 0 && cyc == ack_at);
      dmem_rdata = rdata;
      @(negedge clk);
      if (stall_out) stall_n++;
      if (dmem_req) begin
        req_n++;
        if (req_n == 1) begin
          check32({name, ".addr"}, dmem_addr, exp_addr);
          check32({name, ".we"}, {31'b0, dmem_we}, {31'b0, exp_we});
          check32({name, ".wstrb"}, {28'b0, dmem_wstrb}, {28'b0, exp_strb});
          if (exp_we) check32({name, ".wdata"}, dmem_wdata, exp_wdata);
        end
      end
      if (misalign_fault) mis_n++;
      if (bus_error) berr_n++;
      if (valid_out) got = 1'b1;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      cyc++;
    end
    valid_in = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    check32({name, ".resp_seen"}, 32'(got), 32'd1);
    check32({name, ".stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    check32({name, ".req_cycles"}, 32'(req_n), 32'(exp_req));
    check32({name, ".misalign_cycles"}, 32'(mis_n), {31'b0, exp_mis});
    check32({name, ".bus_error_cycles"}, 32'(berr_n), {31'b0, exp_berr});
    @(negedge clk);
    check32({name, ".idle_after"}, {27'b0, valid_out, stall_out, misalign_fault, bus_error, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=time_expired expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t pe;

    rst           = 1'b0;
    valid_in      = 1'b1;
    is_load       = 1'b1;
    is_store      = 1'b0;
    mem_op        = MEM_OP_W;
    addr_in       = 32'h100;
    store_data_in = 32'h0;
    dmem_ack      = 1'b0;
    dmem_rdata    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check32("reset.dmem_req", {31'b0, dmem_req}, 32'd0);
    check32("reset.dmem_bus", dmem_addr | dmem_wdata | {28'b0, dmem_wstrb} | {31'b0, dmem_we}, 32'd0);
    check32("reset.mem_data", mem_data_out, 32'd0);
    check32("reset.flags", {28'b0, valid_out, stall_out, misalign_fault, bus_error}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    is_load  = 1'b0;

    //   name     ld    st    op         addr      sdata        ack rdata         exp_data      mis   berr  bus_addr  we    strb     wdata        st  rq
    run("lw_100", 1'b1, 1'b0, MEM_OP_W,  32'h100,  32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h100,  1'b0, 4'b0000, 32'h0,        2,  1);
    run("lb_103", 1'b1, 1'b0, MEM_OP_B,  32'h103,  32'h0,        1, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 1'b0, 32'h100,  1'b0, 4'b0000, 32'h0,        2,  1);
    run("lbu_103",1'b1, 1'b0, MEM_OP_BU, 32'h103,  32'h0,        1, 32'h80FF1234, 32'h00000080, 1'b0, 1'b0, 32'h100,  1'b0, 4'b0000, 32'h0,        2,  1);
    run("lhu_102",1'b1, 1'b0, MEM_OP_HU, 32'h102,  32'h0,        1, 32'h80FF1234, 32'h000080FF, 1'b0, 1'b0, 32'h100,  1'b0, 4'b0000, 32'h0,        2,  1);
    run("lh_102", 1'b1, 1'b0, MEM_OP_H,  32'h102,  32'h0,        2, 32'h80FF1234, 32'hFFFF80FF, 1'b0, 1'b0, 32'h100,  1'b0, 4'b0000, 32'h0,        3,  2);
    run("sb_201", 1'b0, 1'b1, MEM_OP_B,  32'h201,  32'h000000A5, 1, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'h200,  1'b1, 4'b0010, 32'hA5A5A5A5, 2,  1);
    run("sh_202", 1'b0, 1'b1, MEM_OP_H,  32'h202,  32'h0000BEEF, 1, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'h200,  1'b1, 4'b1100, 32'hBEEFBEEF, 2,  1);
    run("sw_204", 1'b0, 1'b1, MEM_OP_W,  32'h204,  32'h11223344, 3, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'h204,  1'b1, 4'b1111, 32'h11223344, 4,  3);
    run("lw_mis", 1'b1, 1'b0, MEM_OP_W,  32'h102,  32'h0,        1, 32'h12345678, 32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 4'b0000, 32'h0,        1,  0);
    run("lh_mis", 1'b1, 1'b0, MEM_OP_H,  32'h101,  32'h0,        1, 32'h12345678, 32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 4'b0000, 32'h0,        1,  0);
    run("lw_tmo", 1'b1, 1'b0, MEM_OP_W,  32'h400,  32'h0,        0, 32'h12345678, 32'h0,        1'b0, 1'b1, 32'h400,  1'b0, 4'b0000, 32'h0,        17, 16);
    run("lw_ack16",1'b1,1'b0, MEM_OP_W,  32'h404,  32'h0,       16, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 32'h404,  1'b0, 4'b0000, 32'h0,        17, 16);
    run("ld_st",  1'b1, 1'b1, MEM_OP_BU, 32'h101,  32'hFFFFFFFF, 1, 32'h80FF1234, 32'h00000012, 1'b0, 1'b0, 32'h100,  1'b0, 4'b0000, 32'h0,        2,  1);
    run("op7_w",  1'b1, 1'b0, 3'd7,      32'h10C,  32'h0,        1, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 1'b0, 32'h10C,  1'b0, 4'b0000, 32'h0,        2,  1);
    run("op3_mis",1'b1, 1'b0, 3'd3,      32'h106,  32'h0,        1, 32'h12345678, 32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 4'b0000, 32'h0,        1,  0);

    // Reset while WAIT is outstanding; a late ack must be ignored.
    valid_in = 1'b1;
    is_load  = 1'b1;
    mem_op   = MEM_OP_W;
    addr_in  = 32'h300;
    @(posedge clk);
    #1;
    @(negedge clk);
    check32("rst_mid.req_before", {31'b0, dmem_req}, 32'd1);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    is_load = 1'b0;
    @(negedge clk);
    check32("rst_mid.gated_outputs", {30'b0, valid_out, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    check32("rst_mid.req_dropped", {31'b0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h55;
    @(negedge clk);
    check32("rst_mid.late_ack", {29'b0, dmem_req, valid_out, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check32("rst_mid.after_ack", {29'b0, dmem_req, valid_out, stall_out}, 32'd0);
    check32("rst_mid.mem_data", mem_data_out, 32'd0);
    @(posedge clk);
    #1;

    // Non-memory entries flow straight through with no stall.
    for (int i = 0; i < 6; i++) begin
      valid_in = pat[i];
      is_load  = 1'b0;
      is_store = 1'b0;
      if (pat[i]) begin
        pe.data = 32'h0;
        pe.mis  = 1'b0;
        pe.berr = 1'b0;
        exp_q.push_back(pe);
      end
      @(negedge clk);
      check32("pass.valid_out", {31'b0, valid_out}, {31'b0, pat[i]});
      check32("pass.stall_out", {31'b0, stall_out}, 32'd0);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    @(negedge clk);

    check32("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine; the producer side of the MEM→WB pipeline register.
- Takes a load/store from EX/MEM and runs a req/ack transaction on the data bus.
- Aligns and sign/zero-extends load data and presents it as mem_data for the MEM→WB register.
- Drives stall_out, which holds EX/MEM and the front end while the bus is busy; MEM_WB.enable is tied high, and MEM_WB.valid_in is tied to valid_out.

Parameters:
- TIMEOUT_CYCLES, 16, WAIT cycles without dmem_ack before the access is aborted with bus_error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- valid_in  in  1  EX/MEM entry valid
- is_load  in  1  entry is a load
- is_store  in  1  entry is a store
- mem_op  in  3  size/sign code (package constants)
- addr_in  in  32  effective byte address
- store_data_in  in  32  rs2 value
- mem_data_out  out  32  aligned/extended load result to MEM_WB.mem_data_in
- valid_out  out  1  result valid to MEM_WB.valid_in
- stall_out  out  1  hold upstream stages
- misalign_fault  out  1  1-cycle pulse, misaligned access
- bus_error  out  1  1-cycle pulse, ack timeout
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_ack  in  1  bus completion, 1 cycle
- dmem_rdata  in  32  read word, valid with ack

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset:
  - rst low at a clk edge forces IDLE and sets all registered outputs to 0 (dmem_*, mem_data_out, misalign_fault, bus_error, timeout counter).
  - valid_out and stall_out are combinational and gated to 0 while rst is low.
  - Reset mid-transaction drops dmem_req next edge; a late dmem_ack seen in IDLE is ignored.
- An access is mem_acc = valid_in & (is_load|is_store). is_load and is_store together is illegal: treat as load.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte accesses are always aligned.
- IDLE:
  - No mem_acc:
    - valid_out = valid_in (combinational pass-through).
    - mem_data_out = 0.
    - stall_out = 0.
  - mem_acc, aligned:
    - stall_out = 1, valid_out = 0.
    - Latch op, addr and store data.
    - Next edge: dmem_req=1, dmem_we=is_store, dmem_addr, dmem_wdata, dmem_wstrb driven; go to WAIT.
  - mem_acc, misaligned:
    - stall_out = 1, valid_out = 0.
    - No bus access.
    - Next edge: misalign_fault=1, mem_data_out=0; go to RESP.
- WAIT:
  - stall_out = 1, valid_out = 0.
  - Counter increments each cycle.
  - On dmem_ack:
    - dmem_req=0 next edge.
    - mem_data_out = extracted load data (0 for stores).
    - Go to RESP.
  - If counter reaches TIMEOUT_CYCLES-1 without ack:
    - dmem_req=0, bus_error=1, mem_data_out=0; go to RESP.
  - Ack in the same cycle as timeout: ack wins, no bus_error.
- RESP (exactly 1 cycle):
  - stall_out = 0, valid_out = 1; MEM_WB captures at this edge.
  - Inputs are ignored; EX/MEM advances.
  - Next state IDLE; misalign_fault and bus_error clear.
- Access latency:
  - Aligned access with ack in the first WAIT cycle: 3 cycles, stall high for 2.
  - Misaligned access: 2 cycles.
- Store lanes, with o = addr[1:0]:
  - SB: wstrb = 4'b0001<<o, wdata = {4{byte}}.
  - SH: wstrb = 4'b0011<<o, wdata = {2{half}}.
  - SW: wstrb = 4'hF, wdata = data.
- Load extract: select the byte/half at offset o from dmem_rdata.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Undefined mem_op codes behave as a word access.

Decomposition:
- Package mem_pkg:
  - MEM_OP_B=3'd0, MEM_OP_H=3'd1, MEM_OP_W=3'd2, MEM_OP_BU=3'd4, MEM_OP_HU=3'd5.
  - FSM state encoding.
- One sub-module: mem_lane_align.
  - Combinational.
  - Store replicate/strobe generation and load extract/extend.
  - Reused by a future I-side or AMO unit.

Test Plan:
- LW addr=0x100, ack on the 1st WAIT cycle with rdata=0xDEADBEEF -> dmem_addr=0x100, wstrb=0, dmem_we=0; RESP with mem_data_out=0xDEADBEEF, valid_out=1; stall high exactly 2 cycles.
- LB addr=0x103, rdata=0x80FF1234 -> mem_data_out=0xFFFFFF80. Same with LBU -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
- SB addr=0x201, data=0x000000A5 -> dmem_we=1, dmem_addr=0x200, wstrb=4'b0010, wdata=0xA5A5A5A5; RESP mem_data_out=0. SH addr=0x202 -> wstrb=4'b1100.
- LW addr=0x102 -> no dmem_req ever; misalign_fault pulses 1 cycle; RESP valid_out=1, mem_data_out=0.
- LW with ack never returned (TIMEOUT_CYCLES=16) -> dmem_req high 16 cycles then low, bus_error 1-cycle pulse, RESP; ack arriving exactly on cycle 16 -> no bus_error, data returned.
- rst low during WAIT, then ack arrives 2 cycles after rst releases -> IDLE, dmem_req=0, valid_out=0, ack ignored. Back-to-back non-mem entries -> valid_out follows valid_in each cycle, stall_out=0.
